// File: rtl/result_frame_packer.sv
// result_frame_packer
//
// Packs one completed measurement (14-bit ADC result, 8-bit device address,
// 48-bit timestamp) into a fixed five-word, 16-bit frame for the host-bound
// output FIFO:
//   w0 = {HDR_TAG, seq[3:0], addr[7:0]}
//   w1 = time[47:32], w2 = time[31:16], w3 = time[15:0]
//   w4 = {2'b00, adc[13:0]}
// seq is a 4-bit wrapping frame number that lets the host resynchronise on
// the next header after a lost or abandoned frame.
//
// Handshakes:
//   Input side : sample_valid is a one-cycle strobe, not a held request. A
//                strobe is accepted only in a cycle where in_rdy is high;
//                a strobe seen while in_rdy is low is discarded (never held
//                or retried) and counted in drop_cnt / overflow.
//   Output side: a word is written on every rising edge where data_out_en
//                is high. data_out_en is never raised while fifo_full is
//                high; data_out holds the pending word until it is written.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   sample_valid strobe: adc_in/addr_in/time_in valid this cycle
//   in_rdy       a strobe this cycle will be accepted
//   adc_in       ADC conversion result (14 bits)
//   addr_in      device address (8 bits)
//   time_in      timestamp (48 bits)
//   fifo_full    output FIFO full; suppresses writes
//   data_out     word presented to the FIFO (0 while idle)
//   data_out_en  FIFO write enable
//   overflow     sticky: a sample has been dropped since reset
//   drop_cnt     dropped-sample count, saturating at 255
//   state_dbg    FSM state for observation: 0 = IDLE, 1 = EMIT
module result_frame_packer #(
  parameter logic [3:0] HDR_TAG     = 4'hA,
  parameter int         FRAME_WORDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  output logic        in_rdy,
  input  logic [13:0] adc_in,
  input  logic [7:0]  addr_in,
  input  logic [47:0] time_in,
  input  logic        fifo_full,
  output logic [15:0] data_out,
  output logic        data_out_en,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [2:0] LAST_WIDX = 3'(FRAME_WORDS - 1);

  state_t      state;
  logic [2:0]  widx;
  logic [3:0]  seq;
  logic [13:0] cap_adc;
  logic [7:0]  cap_addr;
  logic [47:0] cap_time;

  // Ready and write enable follow the state register directly, so an
  // asynchronous reset drops data_out_en in the same instant as the state.
  assign in_rdy      = (state == IDLE);
  assign data_out_en = (state == EMIT) && !fifo_full;
  assign state_dbg   = (state == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      widx     <= 3'd0;
      seq      <= 4'd0;
      cap_adc  <= 14'd0;
      cap_addr <= 8'd0;
      cap_time <= 48'd0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            cap_adc  <= adc_in;
            cap_addr <= addr_in;
            cap_time <= time_in;
            widx     <= 3'd0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          // A strobe during a frame is lost; the capture register keeps
          // the frame being emitted.
          if (sample_valid) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
          // widx only moves on an actual write, so a stalled word is
          // neither skipped nor repeated.
          if (!fifo_full) begin
            if (widx == LAST_WIDX) begin
              widx  <= 3'd0;
              seq   <= seq + 4'd1;
              state <= IDLE;
            end else begin
              widx <= widx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = 16'h0000;
    if (state == EMIT) begin
      case (widx)
        3'd0:    data_out = {HDR_TAG, seq, cap_addr};
        3'd1:    data_out = cap_time[47:32];
        3'd2:    data_out = cap_time[31:16];
        3'd3:    data_out = cap_time[15:0];
        3'd4:    data_out = {2'b00, cap_adc};
        default: data_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_result_frame_packer.sv
// Testbench for result_frame_packer. Inputs change 1 ns after the rising
// edge; DUT outputs are observed on the falling edge. The reference model
// is a queue of the words still owed for the current frame: a strobe is
// accepted only when nothing is owed, otherwise it counts as a drop.
module tb_result_frame_packer;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic        in_rdy;
  logic [13:0] adc_in;
  logic [7:0]  addr_in;
  logic [47:0] time_in;
  logic        fifo_full;
  logic [15:0] data_out;
  logic        data_out_en;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        state_dbg;

  result_frame_packer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .in_rdy       (in_rdy),
    .adc_in       (adc_in),
    .addr_in      (addr_in),
    .time_in      (time_in),
    .fifo_full    (fifo_full),
    .data_out     (data_out),
    .data_out_en  (data_out_en),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] wr_words[$];
  int          wr_log[$];
  logic [3:0]  m_seq;
  int          m_drops;
  logic        m_ovf;
  int          cyc;
  int          acc_cyc;
  int          n_acc;
  logic        mon_en;
  logic [15:0] mon_data;
  bit          busy;
  int          n_cmp;
  int          n_err;

  // Model update at the edge, using values captured on the previous falling
  // edge and the bench's own driven inputs.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      busy = (exp_q.size() != 0);
      if (mon_en) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        wr_log.push_back(cyc);
        wr_words.push_back(mon_data);
      end
      if (sample_valid) begin
        if (busy) begin
          if (m_drops < 255) m_drops++;
          m_ovf = 1'b1;
        end else begin
          exp_q.push_back({4'hA, m_seq, addr_in});
          exp_q.push_back(time_in[47:32]);
          exp_q.push_back(time_in[31:16]);
          exp_q.push_back(time_in[15:0]);
          exp_q.push_back({2'b00, adc_in});
          m_seq   = m_seq + 4'd1;
          acc_cyc = cyc;
          n_acc++;
        end
      end
    end
  end

  // Continuous checks on the falling edge.
  always @(negedge clk) begin
    mon_en   = data_out_en;
    mon_data = data_out;
    if (rst) begin
      n_cmp++;
      if (data_out_en !== 1'b0) begin
        n_err++;
        $display("FAIL rst_en: got %b want 0", data_out_en);
      end
    end else begin
      n_cmp++;
      if (in_rdy !== (exp_q.size() == 0)) begin
        n_err++;
        $display("FAIL in_rdy: got %b want %b at cyc %0d", in_rdy, exp_q.size() == 0, cyc);
      end
      n_cmp++;
      if (data_out_en !== ((exp_q.size() != 0) && !fifo_full)) begin
        n_err++;
        $display("FAIL data_out_en: got %b want %b at cyc %0d", data_out_en,
                 (exp_q.size() != 0) && !fifo_full, cyc);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        if (data_out !== exp_q[0]) begin
          n_err++;
          $display("FAIL word: got %h want %h at cyc %0d", data_out, exp_q[0], cyc);
        end
      end else if (data_out !== 16'h0000) begin
        n_err++;
        $display("FAIL idle_data: got %h want 0000 at cyc %0d", data_out, cyc);
      end
      n_cmp++;
      if (drop_cnt !== 8'(m_drops) || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL drops: got cnt=%0d ovf=%b want cnt=%0d ovf=%b", drop_cnt, overflow, m_drops, m_ovf);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input logic v, input logic [13:0] a, input logic [7:0] ad,
                            input logic [47:0] t);
    sample_valid = v;
    adc_in       = a;
    addr_in      = ad;
    time_in      = t;
  endtask

  task automatic set_random_sample(input logic v);
    set_sample(v, 14'($urandom), 8'($urandom), {16'($urandom), 32'($urandom)});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    m_seq   = 4'd0;
    m_drops = 0;
    m_ovf   = 1'b0;
    mon_en  = 1'b0;
    #1;
    n_cmp++;
    if (data_out_en !== 1'b0 || in_rdy !== 1'b1 || data_out !== 16'h0000 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0 || state_dbg !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: en=%b rdy=%b data=%h ovf=%b cnt=%0d st=%b want 0 1 0000 0 0 0",
               data_out_en, in_rdy, data_out, overflow, drop_cnt, state_dbg);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words still owed, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    n_cmp++;
    if (in_rdy !== 1'b1 || data_out !== 16'h0000 || data_out_en !== 1'b0 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b data=%h en=%b ovf=%b cnt=%0d want 1 0000 0 0 0",
               in_rdy, data_out, data_out_en, overflow, drop_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] want[5];
    want = '{16'hA005, 16'h0123, 16'h4567, 16'h89AB, 16'h1ABC};
    wr_log.delete();
    wr_words.delete();
    set_sample(1'b1, 14'h1ABC, 8'h05, 48'h0123_4567_89AB);
    tick();
    set_sample(1'b0, 14'h0, 8'h0, 48'h0);
    wait_idle(20);
    tick();
    n_cmp++;
    if (wr_log.size() != 5) begin
      n_err++;
      $display("FAIL single_count: got %0d writes want 5", wr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (wr_words[i] !== want[i] || wr_log[i] != acc_cyc + 1 + i) begin
          n_err++;
          $display("FAIL single_w%0d: got %h@%0d want %h@%0d", i, wr_words[i], wr_log[i],
                   want[i], acc_cyc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    wr_log.delete();
    wr_words.delete();
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 20 && wr_log.size() < 2; i++) tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (data_out_en !== 1'b0 || exp_q.size() != 3 || data_out !== exp_q[0]) begin
        n_err++;
        $display("FAIL bp_hold: en=%b owed=%0d data=%h want en=0 owed=3", data_out_en,
                 exp_q.size(), data_out);
      end
    end
    fifo_full = 1'b0;
    wait_idle(20);
    tick();
    n_cmp++;
    if (wr_log.size() != 5 || wr_log[4] != acc_cyc + 8) begin
      n_err++;
      $display("FAIL bp_done: writes=%0d last@%0d want 5 writes, last@%0d", wr_log.size(),
               wr_log[wr_log.size()-1], acc_cyc + 8);
    end
  endtask

  task automatic test_toggle_full();
    int lows;
    wr_log.delete();
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    lows = 0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      fifo_full = ~fifo_full;
      if (!fifo_full) lows++;
      tick();
    end
    fifo_full = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || wr_log.size() != 5 || lows != 5) begin
      n_err++;
      $display("FAIL toggle: owed=%0d writes=%0d low_cycles=%0d want 0 5 5", exp_q.size(),
               wr_log.size(), lows);
    end
    wait_idle(20);
  endtask

  task automatic test_seq_wrap();
    logic [15:0] hdr;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      set_random_sample(1'b1);
      addr_in = 8'h3C;
      tick();
      sample_valid = 1'b0;
      hdr = {4'hA, 4'(i), 8'h3C};
      n_cmp++;
      if (data_out !== hdr) begin
        n_err++;
        $display("FAIL wrap_hdr%0d: got %h want %h", i, data_out, hdr);
      end
      wait_idle(20);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    tick();
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL drop_one: ovf=%b cnt=%0d want 1 1", overflow, drop_cnt);
    end
    wait_idle(20);
    // 300 drops against a stalled frame
    apply_reset();
    fifo_full = 1'b1;
    set_random_sample(1'b1);
    tick();
    for (int i = 0; i < 300; i++) begin
      set_random_sample(1'b1);
      tick();
    end
    sample_valid = 1'b0;
    fifo_full    = 1'b0;
    n_cmp++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL drop_sat: cnt=%0d ovf=%b want 255 1", drop_cnt, overflow);
    end
    wait_idle(20);
  endtask

  task automatic test_reset_mid();
    wr_log.delete();
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 20 && wr_log.size() < 2; i++) tick();
    apply_reset();
    tick();
    n_cmp++;
    if (data_out_en !== 1'b0 || in_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_idle: en=%b rdy=%b want 0 1", data_out_en, in_rdy);
    end
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    n_cmp++;
    if (data_out[15:8] !== 8'hA0) begin
      n_err++;
      $display("FAIL reset_mid_seq: header %h want tag/seq A0", data_out);
    end
    wait_idle(20);
  endtask

  task automatic test_collision();
    int acc_before;
    apply_reset();
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 1; i++) tick();
    // w4 is on the bus and will be written at the next edge
    acc_before = n_acc;
    set_random_sample(1'b1);
    tick();
    n_cmp++;
    if (drop_cnt !== 8'd1 || n_acc != acc_before) begin
      n_err++;
      $display("FAIL collision_drop: cnt=%0d accepted=%0d want 1 0", drop_cnt, n_acc - acc_before);
    end
    set_random_sample(1'b1);
    tick();
    sample_valid = 1'b0;
    n_cmp++;
    if (in_rdy !== 1'b0 || drop_cnt !== 8'd1 || n_acc != acc_before + 1) begin
      n_err++;
      $display("FAIL collision_accept: rdy=%b cnt=%0d accepted=%0d want 0 1 1", in_rdy, drop_cnt,
               n_acc - acc_before);
    end
    wait_idle(20);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      set_random_sample($urandom_range(0, 4) == 0);
      tick();
    end
    sample_valid = 1'b0;
    fifo_full    = 1'b0;
    wait_idle(40);
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    adc_in       = 14'd0;
    addr_in      = 8'd0;
    time_in      = 48'd0;
    fifo_full    = 1'b0;
    m_seq        = 4'd0;
    m_drops      = 0;
    m_ovf        = 1'b0;
    mon_en       = 1'b0;
    mon_data     = 16'd0;
    cyc          = 0;
    acc_cyc      = 0;
    n_acc        = 0;
    n_cmp        = 0;
    n_err        = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_toggle_full();
    test_seq_wrap();
    test_drop();
    test_reset_mid();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
